btn_debounce_multi: RTL and testbench
=====================================

BTN_DEBOUNCE_MULTI -- requirements
Module: btn_debounce_multi

Interface
REQ-001 Parameter: N_CH, 4, number of independent button channels (1..32).
REQ-002 Parameter: STABLE_CNT, 10000, consecutive synchronized cycles required to accept a new level (>=1).
REQ-003 Parameter: ACTIVE_LOW, 0, when 1, btn_in is inverted before synchronization (pressed = 0 at pin).
REQ-004 Parameter: LONG_CNT, 1000000, cycles of accepted-pressed level before a long-press event (>STABLE_CNT).
REQ-005 Port: clk  input  1  system clock, all logic on rising edge.
REQ-006 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-007 Port: btn_in  input  N_CH  raw asynchronous button pins.
REQ-008 Port: level  output  N_CH  debounced pressed level, 1 = pressed.
REQ-009 Port: press  output  N_CH  one-cycle pulse on accepted 0->1 of level.
REQ-010 Port: release  output  N_CH  one-cycle pulse on accepted 1->0 of level.
REQ-011 Port: long_press  output  N_CH  one-cycle pulse on long-press detection.

Function
REQ-012 Each channel SHALL pass btn_in (after ACTIVE_LOW inversion) through a 2-flop synchronizer; channels fully independent.
REQ-013 Counter width SHALL be $clog2(STABLE_CNT+1); counter SHALL never wrap.
REQ-014 Synchronized input == level: counter SHALL clear to 0 that cycle.
REQ-015 Synchronized input != level: counter SHALL increment; on the cycle it equals STABLE_CNT-1, level SHALL toggle next edge and counter SHALL clear.
REQ-016 Debounce SHALL be symmetric: both press and release require STABLE_CNT consecutive differing cycles.
REQ-017 Latency pin-change to level-change SHALL be exactly 2+STABLE_CNT cycles for a clean edge.
REQ-018 Any glitch returning to current level before acceptance SHALL restart the count from 0; level SHALL not change.
REQ-019 press/release SHALL assert in the same cycle level changes, for exactly one cycle; never both on one channel in one cycle.
REQ-020 Simultaneous events on multiple channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-021 rstn low SHALL asynchronously clear synchronizers, counters, level, press, release, long_press to 0 (synchronizers to the not-pressed value).
REQ-022 Reset mid-count SHALL discard progress; after release of rstn a held button SHALL take the full 2+STABLE_CNT cycles to be accepted, with a press pulse.

Configuration
REQ-023 Macro BTN_DEBOUNCE_LONG_PRESS_EN defined: per-channel long counter SHALL count while level==1, pulse long_press once when count reaches LONG_CNT-1, then saturate until level returns 0 (clears counter).
REQ-024 Macro undefined: long counter logic SHALL be absent, long_press SHALL be tied to 0, LONG_CNT ignored.

Structure
REQ-025 Shared package btn_pkg SHALL hold default STABLE_CNT/LONG_CNT constants and the cnt-width helper function.
REQ-026 One sub-module debounce_ch (single channel: sync, counter, level, pulses, optional long counter) SHALL be instantiated N_CH times via generate.

Verification (STABLE_CNT=8, LONG_CNT=40, N_CH=4, long-press macro defined unless noted)
REQ-027 btn_in[0] 0->1 held -> level[0] rises exactly 10 cycles later, press[0] one-cycle pulse same cycle, other channels stay 0.
REQ-028 btn_in[1] high 7 cycles then low, repeat 5 times -> level[1], press[1] never assert.
REQ-029 level[2]=1 then btn_in[2] low 8 cycles -> release[2] pulse and level[2]=0 at cycle 10; 3-cycle low glitch -> no release.
REQ-030 btn_in[3] held 60 cycles -> press[3] at 10, long_press[3] single pulse 40 cycles after level rise, no repeat; with macro undefined long_press stays 0.
REQ-031 rstn pulsed low at count 5 with btn_in[0]=1 -> all outputs 0 immediately; level[0] rises 10 cycles after rstn deassert.
REQ-032 ACTIVE_LOW=1, btn_in all 1 from reset -> no pulses; btn_in[0] 1->0 -> press[0] after 10 cycles.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants, per-channel event bundle and counter-width helper for the
// multi-channel button debouncer.
package btn_pkg;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_STABLE_CNT = 10000;
  localparam int DEF_LONG_CNT   = 1000000;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic longPress;
  } chEvents_t;

  // Bits needed to hold 0..maxVal; a counter of this width never wraps.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button pins in, debounced levels and event pulses out; the slave side is the
// debouncer, the master side is whoever owns the pins and consumes the events.
interface btn_debounce_multi_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] btn_in_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] long_press_o;

  modport master (
    output btn_in_i,
    input  level_o,
    input  press_o,
    input  release_o,
    input  long_press_o
  );

  modport slave (
    input  btn_in_i,
    output level_o,
    output press_o,
    output release_o,
    output long_press_o
  );

endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, symmetric stability counter,
// press/release pulses and, with BTN_DEBOUNCE_LONG_PRESS_EN, a long-press pulse.
module debounce_ch
  import btn_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int ACTIVE_LOW = 0
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      btn_i,
  output chEvents_t evt_o
);

  localparam int             CW   = cntWidth(STABLE_CNT);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_CNT - 1);

  logic          rawBtn;
  logic [1:0]    sync_q;
  logic          syncBtn;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          longPress;

  // Normalise to pressed = 1 before synchronizing so reset means "not pressed".
  assign rawBtn  = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;
  assign syncBtn = sync_q[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], rawBtn};
    end
  end

  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (syncBtn != level_q) begin
      if (cnt_q == LAST) begin
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int            LW    = cntWidth(LONG_CNT);
  localparam logic [LW-1:0] LFIRE = LW'(LONG_CNT - 1);
  localparam logic [LW-1:0] LSAT  = LW'(LONG_CNT);

  logic [LW-1:0] longCnt_q, longCnt_d;
  logic          longPress_q, longPress_d;

  // Counter parks at LONG_CNT after firing so the pulse cannot repeat.
  always_comb begin
    longCnt_d   = '0;
    longPress_d = 1'b0;
    if (level_q) begin
      longCnt_d   = (longCnt_q == LSAT) ? LSAT : longCnt_q + LW'(1);
      longPress_d = (longCnt_q == LFIRE);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      longCnt_q   <= '0;
      longPress_q <= 1'b0;
    end else begin
      longCnt_q   <= longCnt_d;
      longPress_q <= longPress_d;
    end
  end

  assign longPress = longPress_q;
`else
  localparam int unusedLongCnt = LONG_CNT;
  assign longPress = 1'b0;
`endif

  assign evt_o.level     = level_q;
  assign evt_o.press     = press_q;
  assign evt_o.rel       = release_q;
  assign evt_o.longPress = longPress;

endmodule

// File: rtl/btn_debounce_multi.sv
// N_CH independent debounce channels behind one interface port.
// Long-press detection is built only when BTN_DEBOUNCE_LONG_PRESS_EN is defined.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int ACTIVE_LOW = 0,
  parameter int LONG_CNT   = DEF_LONG_CNT
) (
  input  logic                  clk,
  input  logic                  rstn,
  btn_debounce_multi_if.slave   bus
);

  chEvents_t       evt [N_CH];
  logic [N_CH-1:0] levelVec;
  logic [N_CH-1:0] pressVec;
  logic [N_CH-1:0] releaseVec;
  logic [N_CH-1:0] longVec;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT (STABLE_CNT),
      .LONG_CNT   (LONG_CNT),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk   (clk),
      .rstn  (rstn),
      .btn_i (bus.btn_in_i[g]),
      .evt_o (evt[g])
    );

    assign levelVec[g]   = evt[g].level;
    assign pressVec[g]   = evt[g].press;
    assign releaseVec[g] = evt[g].rel;
    assign longVec[g]    = evt[g].longPress;
  end

  assign bus.level_o      = levelVec;
  assign bus.press_o      = pressVec;
  assign bus.release_o    = releaseVec;
  assign bus.long_press_o = longVec;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: an active-high and an active-low instance checked
// every cycle against a run-length model, plus hand-computed latency checks.
module tb_btn_debounce_multi;

  localparam int N_CH       = 4;
  localparam int STABLE_CNT = 8;
  localparam int LONG_CNT   = 40;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  btn_debounce_multi_if #(.N_CH(N_CH)) busA ();
  btn_debounce_multi_if #(.N_CH(N_CH)) busB ();

  btn_debounce_multi #(
    .N_CH(N_CH), .STABLE_CNT(STABLE_CNT), .ACTIVE_LOW(0), .LONG_CNT(LONG_CNT)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(busA)
  );

  btn_debounce_multi #(
    .N_CH(N_CH), .STABLE_CNT(STABLE_CNT), .ACTIVE_LOW(1), .LONG_CNT(LONG_CNT)
  ) dutAl (
    .clk(clk), .rstn(rstn), .bus(busB)
  );

  always #5 clk = ~clk;

  // Model: pressed value is seen two edges late; level flips after STABLE_CNT
  // consecutive differing cycles; long press fires LONG_CNT cycles into a press.
  bit              mLevel [2][N_CH];
  int              mRun   [2][N_CH];
  int              mHeld  [2][N_CH];
  bit              mPipe  [2][N_CH][2];
  logic [N_CH-1:0] expVec [2][4];

  logic [N_CH-1:0] seenLevel [2];
  logic [N_CH-1:0] seenPress [2];
  logic [N_CH-1:0] seenRel   [2];

  function automatic bit pressedPin(input int u, input int c);
    return (u == 0) ? busA.btn_in_i[c] : ~busB.btn_in_i[c];
  endfunction

  function automatic logic [N_CH-1:0] outVec(input int u, input int which);
    logic [N_CH-1:0] v;
    v = '0;
    case (which)
      0: v = (u == 0) ? busA.level_o      : busB.level_o;
      1: v = (u == 0) ? busA.press_o      : busB.press_o;
      2: v = (u == 0) ? busA.release_o    : busB.release_o;
      default: v = (u == 0) ? busA.long_press_o : busB.long_press_o;
    endcase
    return v;
  endfunction

  task automatic modelStep();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!rstn) begin
          mLevel[u][c] = 1'b0;
          mRun[u][c]   = 0;
          mHeld[u][c]  = 0;
          mPipe[u][c][0] = 1'b0;
          mPipe[u][c][1] = 1'b0;
          for (int w = 0; w < 4; w++) expVec[u][w][c] = 1'b0;
        end else begin
          expVec[u][1][c] = 1'b0;
          expVec[u][2][c] = 1'b0;
          expVec[u][3][c] = 1'b0;
          if (mLevel[u][c]) begin
            mHeld[u][c]++;
            if (LONG_EN && mHeld[u][c] == LONG_CNT) expVec[u][3][c] = 1'b1;
          end else begin
            mHeld[u][c] = 0;
          end
          if (mPipe[u][c][1] != mLevel[u][c]) begin
            mRun[u][c]++;
            if (mRun[u][c] == STABLE_CNT) begin
              mRun[u][c] = 0;
              mLevel[u][c] = ~mLevel[u][c];
              if (mLevel[u][c]) expVec[u][1][c] = 1'b1;
              else              expVec[u][2][c] = 1'b1;
            end
          end else begin
            mRun[u][c] = 0;
          end
          mPipe[u][c][1] = mPipe[u][c][0];
          mPipe[u][c][0] = pressedPin(u, c);
          expVec[u][0][c] = mLevel[u][c];
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      modelStep();
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    string fld [4];
    fld[0] = "level"; fld[1] = "press"; fld[2] = "release"; fld[3] = "long_press";
    forever begin
      @(negedge clk);
      if (rstn) begin
        for (int u = 0; u < 2; u++)
          for (int w = 0; w < 4; w++)
            checkOutput($sformatf("cyc_%s_u%0d", fld[w], u), int'(outVec(u, w)), int'(expVec[u][w]));
      end
    end
  end

  task automatic applyStimulus(input int u, input int c, input bit val);
    if (u == 0) busA.btn_in_i[c] = val;
    else        busB.btn_in_i[c] = val;
  endtask

  task automatic clearSeen();
    for (int u = 0; u < 2; u++) begin
      seenLevel[u] = '0;
      seenPress[u] = '0;
      seenRel[u]   = '0;
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        seenLevel[u] |= outVec(u, 0);
        seenPress[u] |= outVec(u, 1);
        seenRel[u]   |= outVec(u, 2);
      end
    end
  endtask

  // Cycles until level[c] reaches target (-1 on timeout) and the matching pulse bit.
  task automatic waitLevel(input int u, input int c, input bit target,
                           output int cycles, output int pulse);
    logic [N_CH-1:0] lv, pv;
    cycles = -1;
    pulse  = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      #1;
      lv = outVec(u, 0);
      pv = outVec(u, target ? 1 : 2);
      if (lv[c] == target) begin
        cycles = i;
        pulse  = int'(pv[c]);
        break;
      end
    end
  endtask

  initial begin
    int lat, pulse, longCount, longAt;
    logic [N_CH-1:0] lv;
    busA.btn_in_i = '0;
    busB.btn_in_i = '1;
    clearSeen();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_level", int'(busA.level_o), 0);
    checkOutput("rst_press", int'(busA.press_o), 0);
    rstn = 1'b1;
    runCycles(3);

    // Clean press on channel 0, then its release
    applyStimulus(0, 0, 1'b1);
    waitLevel(0, 0, 1'b1, lat, pulse);
    checkOutput("t1_press_latency", lat, 10);
    checkOutput("t1_press_pulse", pulse, 1);
    lv = busA.level_o;
    checkOutput("t1_other_levels", int'(lv[3:1]), 0);
    applyStimulus(0, 0, 1'b0);
    waitLevel(0, 0, 1'b0, lat, pulse);
    checkOutput("t1_release_latency", lat, 10);
    runCycles(2);

    // Bouncing channel 1 never holds long enough
    clearSeen();
    for (int r = 0; r < 5; r++) begin
      applyStimulus(0, 1, 1'b1);
      runCycles(7);
      applyStimulus(0, 1, 1'b0);
      runCycles(3);
    end
    runCycles(5);
    checkOutput("t2_no_level1", int'(seenLevel[0][1]), 0);
    checkOutput("t2_no_press1", int'(seenPress[0][1]), 0);

    // Channel 2: short low glitch ignored, full low accepted
    applyStimulus(0, 2, 1'b1);
    waitLevel(0, 2, 1'b1, lat, pulse);
    checkOutput("t3_press_latency", lat, 10);
    runCycles(2);
    clearSeen();
    applyStimulus(0, 2, 1'b0);
    runCycles(3);
    applyStimulus(0, 2, 1'b1);
    runCycles(12);
    checkOutput("t3_glitch_no_release", int'(seenRel[0][2]), 0);
    lv = busA.level_o;
    checkOutput("t3_glitch_level_held", int'(lv[2]), 1);
    applyStimulus(0, 2, 1'b0);
    waitLevel(0, 2, 1'b0, lat, pulse);
    checkOutput("t3_release_latency", lat, 10);
    checkOutput("t3_release_pulse", pulse, 1);
    runCycles(2);

    // Channel 3 held 60 cycles: one long press 40 cycles after acceptance
    applyStimulus(0, 3, 1'b1);
    waitLevel(0, 3, 1'b1, lat, pulse);
    checkOutput("t4_press_latency", lat, 10);
    longCount = 0;
    longAt    = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      #1;
      lv = busA.long_press_o;
      if (lv[3]) begin
        longCount++;
        longAt = k;
      end
    end
    checkOutput("t4_long_count", longCount, LONG_EN ? 1 : 0);
    checkOutput("t4_long_at", longAt, LONG_EN ? 40 : 0);
    applyStimulus(0, 3, 1'b0);
    runCycles(12);

    // Reset mid-count discards progress
    applyStimulus(0, 1, 1'b1);
    runCycles(12);
    applyStimulus(0, 0, 1'b1);
    runCycles(7);
    rstn = 1'b0;
    #1;
    checkOutput("t5_rst_level", int'(busA.level_o), 0);
    checkOutput("t5_rst_pulses", int'({busA.press_o, busA.release_o, busA.long_press_o}), 0);
    runCycles(2);
    rstn = 1'b1;
    waitLevel(0, 0, 1'b1, lat, pulse);
    checkOutput("t5_press_latency", lat, 10);
    checkOutput("t5_press_pulse", pulse, 1);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 1, 1'b0);
    runCycles(14);

    // Active-low instance idle at 1 saw nothing; a 1->0 pin edge is a press
    checkOutput("t6_idle_levels", int'(seenLevel[1]), 0);
    checkOutput("t6_idle_press", int'(seenPress[1]), 0);
    applyStimulus(1, 0, 1'b0);
    waitLevel(1, 0, 1'b1, lat, pulse);
    checkOutput("t6_press_latency", lat, 10);
    checkOutput("t6_press_pulse", pulse, 1);
    runCycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
